color_batch_arbiter: RTL and testbench
======================================

// Module: color_batch_arbiter
// PURPOSE
//  Round-robin scheduler sharing one downstream batch port between NUM_CH colour batch buffers (R,G,B).
//  Each channel buffer emits a 1-cycle batch-ready pulse with its batch word; this block captures the word
//  into a 1-deep per-channel holding slot, then grants slots in fair order to a valid/ready output.
//  Sits between the per-channel batch buffers and the matrix packet/SPI framer in the rgb clock domain.
// PARAMETERS
//  NUM_CH      3   number of requesting channel buffers (>=2)
//  BATCH_SIZE  8   colours per batch; localparam DATA_W = 8*BATCH_SIZE
//  localparam CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//  I_rgb_clk          in   1               single clock, all logic posedge
//  I_rst_n            in   1               asynchronous active-low reset
//  I_ch_batch_ready   in   NUM_CH          per-channel 1-cycle batch-ready pulse
//  I_ch_batch_color   in   NUM_CH*DATA_W   channel c word at [c*DATA_W +: DATA_W], valid in pulse cycle
//  O_batch_valid      out  1               output word valid
//  I_batch_ready      in   1               downstream accept; transfer = valid && ready at posedge
//  O_batch_color      out  DATA_W          granted batch word
//  O_batch_ch         out  CH_W            source channel of O_batch_color
//  O_overrun          out  NUM_CH          sticky per-channel overrun flags
//  I_overrun_clr      in   1               clears O_overrun (and counter if enabled)
// BEHAVIOUR
//  Reset: O_batch_valid=0, O_batch_color=0, O_batch_ch=0, O_overrun=0, all slots empty, rr_last=NUM_CH-1.
//  Capture: at posedge with I_ch_batch_ready[c]=1 and slot c empty (or emptied same edge by grant),
//   slot c <= I_ch_batch_color word, full[c]<=1.
//  Overrun: pulse on c while slot c full and not granted that edge -> new word dropped, old kept,
//   O_overrun[c]<=1. Granted-and-refilled same edge is NOT an overrun.
//  Output register load condition: load_en = !O_batch_valid || I_batch_ready.
//  Grant: if load_en and any full[] (state as of before edge), pick first full channel searching
//   rr_last+1, rr_last+2 ... mod NUM_CH; load O_batch_color/O_batch_ch, O_batch_valid<=1,
//   full[g]<=0, rr_last<=g. Pulse in the same cycle is not eligible (it only fills its slot).
//  If load_en and no slot full: O_batch_valid<=0 (data/ch hold last value).
//  Output stable: while O_batch_valid && !I_batch_ready, O_batch_color/O_batch_ch do not change.
//  Latency: pulse sampled at edge E, idle output -> O_batch_valid high after edge E+1.
//  Throughput: one word per cycle when I_batch_ready held high and slots full.
//  I_overrun_clr: O_overrun<=0 at that edge; an overrun at the same edge wins (flag set).
//  No FSM beyond slot-full flags + output register; rr_last wraps NUM_CH-1 -> 0.
//  Reset mid-transfer: all pending slots and the output word discarded, no residue after release.
// CONFIGURATION
//  `BATCH_ARB_OVERRUN_CNT_EN defined: extra port O_overrun_cnt out 16, counts dropped batches over
//   all channels (+k for k simultaneous drops), saturates at 16'hFFFF, reset 0, cleared by I_overrun_clr
//   (a same-edge drop loads the drop count instead of 0).
//  Not defined: port and counter absent; sticky flags only.
// STRUCTURE
//  Package color_batch_pkg: BATCH_SIZE_DEF=8, NUM_CH_DEF=3, typedef logic [7:0] color_t,
//   CH_R=0/CH_G=1/CH_B=2 constants, OVR_CNT_W=16.
//  Sub-module rr_pick #(NUM_CH): comb. inputs req[NUM_CH], last[CH_W]; outputs gnt_valid, gnt_idx.
// TESTING
//  1 Reset: hold I_rst_n=0 with pulses active -> all outputs 0, rr_last=2; release, first grant ch0 if all pend.
//  2 Fairness: pulse ch0,1,2 same cycle, I_batch_ready=1 -> O_batch_ch 0,1,2 on 3 consecutive cycles,
//    valid from E+1; repeat -> order restarts at 0.
//  3 Backpressure: ch1 word 64'hA5.., I_batch_ready=0 for 10 cycles -> valid=1, color/ch stable; ready=1 -> 1 transfer.
//  4 Overrun: ready=0, two ch2 pulses (64'h11.., 64'h22..) -> O_overrun=3'b100, output 64'h11..;
//    with `BATCH_ARB_OVERRUN_CNT_EN O_overrun_cnt=1; I_overrun_clr -> 0.
//  5 Same-edge grant+refill: ch0 slot granted at edge of new ch0 pulse -> no overrun, new word output next.
//  6 Async reset mid-stream with valid=1 -> valid drops without clock; no stale word after release.

Source files
------------

// File: rtl/color_batch_arbiter_pkg.sv
// Shared types and constants for the colour batch arbiter slice.
package color_batch_pkg;

    localparam int BATCH_SIZE_DEF = 8;
    localparam int NUM_CH_DEF     = 3;
    localparam int OVR_CNT_W      = 16;

    typedef logic [7:0] color_t;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

endpackage

// File: rtl/color_batch_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_CH.
module rr_pick #(
    parameter  int NUM_CH = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_idx
);

    logic [CH_W-1:0] cand;

    // Scan from the farthest candidate to the nearest so the nearest match is written last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CH_W'((int'(last) + i) % NUM_CH);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/color_batch_arbiter.sv
// Round-robin arbiter sharing one valid/ready batch port between per-channel 1-deep slots.
// Optional macro BATCH_ARB_OVERRUN_CNT_EN adds a saturating dropped-batch counter O_overrun_cnt.
module color_batch_arbiter
    import color_batch_pkg::*;
#(
    parameter  int NUM_CH     = NUM_CH_DEF,
    parameter  int BATCH_SIZE = BATCH_SIZE_DEF,
    localparam int DATA_W     = $bits(color_t) * BATCH_SIZE,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     I_rgb_clk,
    input  logic                     I_rst_n,
    input  logic [NUM_CH-1:0]        I_ch_batch_ready,
    input  logic [NUM_CH*DATA_W-1:0] I_ch_batch_color,
    output logic                     O_batch_valid,
    input  logic                     I_batch_ready,
    output logic [DATA_W-1:0]        O_batch_color,
    output logic [CH_W-1:0]          O_batch_ch,
    output logic [NUM_CH-1:0]        O_overrun,
`ifdef BATCH_ARB_OVERRUN_CNT_EN
    output logic [OVR_CNT_W-1:0]     O_overrun_cnt,
`endif
    input  logic                     I_overrun_clr
);

    logic [NUM_CH-1:0] slot_vld_p0;
    logic [DATA_W-1:0] slot_word_p0 [NUM_CH];
    logic [CH_W-1:0]   rr_last;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;
    logic              load_en;
    logic              grant_fire;
    logic [NUM_CH-1:0] granted;
    logic [NUM_CH-1:0] capture;
    logic [NUM_CH-1:0] drop;

    rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
        .req       (slot_vld_p0),
        .last      (rr_last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign load_en    = !O_batch_valid || I_batch_ready;
    assign grant_fire = load_en && gnt_valid;

    // A slot granted on this edge can take a new word on the same edge without counting as overrun.
    always_comb begin
        granted = '0;
        capture = '0;
        drop    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            granted[c] = grant_fire && (gnt_idx == CH_W'(c));
            capture[c] = I_ch_batch_ready[c] && (!slot_vld_p0[c] || granted[c]);
            drop[c]    = I_ch_batch_ready[c] && slot_vld_p0[c] && !granted[c];
        end
    end

    // Stage p0: per-channel holding slots
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            slot_vld_p0 <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (capture[c])
                    slot_vld_p0[c] <= 1'b1;
                else if (granted[c])
                    slot_vld_p0[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge I_rgb_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (capture[c])
                slot_word_p0[c] <= I_ch_batch_color[c*DATA_W +: DATA_W];
        end
    end

    // Stage p1: output register toward the framer
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_batch_valid <= 1'b0;
            O_batch_color <= '0;
            O_batch_ch    <= '0;
            rr_last       <= CH_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (gnt_valid) begin
                O_batch_valid <= 1'b1;
                O_batch_color <= slot_word_p0[gnt_idx];
                O_batch_ch    <= gnt_idx;
                rr_last       <= gnt_idx;
            end else begin
                O_batch_valid <= 1'b0;
            end
        end
    end

    // A drop on the clearing edge wins over the clear.
    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            O_overrun <= '0;
        else
            O_overrun <= (I_overrun_clr ? '0 : O_overrun) | drop;
    end

`ifdef BATCH_ARB_OVERRUN_CNT_EN
    function automatic logic [OVR_CNT_W-1:0] drop_count(input logic [NUM_CH-1:0] v);
        logic [OVR_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++)
            n = n + OVR_CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [OVR_CNT_W-1:0] sat_add(input logic [OVR_CNT_W-1:0] a,
                                                     input logic [OVR_CNT_W-1:0] b);
        logic [OVR_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[OVR_CNT_W] ? {OVR_CNT_W{1'b1}} : sum[OVR_CNT_W-1:0];
    endfunction

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            O_overrun_cnt <= '0;
        else if (I_overrun_clr)
            O_overrun_cnt <= drop_count(drop);
        else
            O_overrun_cnt <= sat_add(O_overrun_cnt, drop_count(drop));
    end
`endif

endmodule

// File: tb/tb_color_batch_arbiter.sv
// Directed bench for color_batch_arbiter (NUM_CH=3, BATCH_SIZE=8).
module tb_color_batch_arbiter;
    import color_batch_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   ch_ready = '0;
    logic [191:0] ch_color = '0;
    logic         valid;
    logic         ready = 1'b0;
    logic [63:0]  color;
    logic [1:0]   ch;
    logic [2:0]   overrun;
    logic         ovr_clr = 1'b0;
`ifdef BATCH_ARB_OVERRUN_CNT_EN
    logic [15:0]  ovr_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    color_batch_arbiter #(.NUM_CH(3), .BATCH_SIZE(8)) dut (
        .I_rgb_clk        (clk),
        .I_rst_n          (rst_n),
        .I_ch_batch_ready (ch_ready),
        .I_ch_batch_color (ch_color),
        .O_batch_valid    (valid),
        .I_batch_ready    (ready),
        .O_batch_color    (color),
        .O_batch_ch       (ch),
        .O_overrun        (overrun),
`ifdef BATCH_ARB_OVERRUN_CNT_EN
        .O_overrun_cnt    (ovr_cnt),
`endif
        .I_overrun_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int c, input logic [63:0] w);
        ch_ready = ch_ready | (3'b001 << c);
        ch_color[c*64 +: 64] = w;
    endtask

    task automatic no_pulse();
        ch_ready = '0;
    endtask

    initial begin
        // Reset held with pulses active
        #1 rst_n = 1'b0;
        pulse(CH_R, 64'h0101010101010101);
        pulse(CH_G, 64'h0202020202020202);
        pulse(CH_B, 64'h0303030303030303);
        repeat (3) tick();
        chk("rst_valid",   64'(valid),   64'd0);
        chk("rst_color",   color,        64'd0);
        chk("rst_ch",      64'(ch),      64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_rr_last", 64'(dut.rr_last), 64'd2);
`ifdef BATCH_ARB_OVERRUN_CNT_EN
        chk("rst_cnt", 64'(ovr_cnt), 64'd0);
`endif

        // Release with all three pending; fairness ch0,ch1,ch2
        rst_n = 1'b1;
        tick();
        no_pulse();
        chk("lat_valid_E", 64'(valid), 64'd0);
        ready = 1'b1;
        tick();
        chk("rr1_valid", 64'(valid), 64'd1);
        chk("rr1_ch0",   64'(ch),    64'd0);
        chk("rr1_col0",  color,      64'h0101010101010101);
        tick();
        chk("rr1_ch1",   64'(ch),    64'd1);
        chk("rr1_col1",  color,      64'h0202020202020202);
        tick();
        chk("rr1_ch2",   64'(ch),    64'd2);
        chk("rr1_col2",  color,      64'h0303030303030303);
        tick();
        chk("rr1_drain", 64'(valid), 64'd0);

        pulse(CH_R, 64'h1010101010101010);
        pulse(CH_G, 64'h2020202020202020);
        pulse(CH_B, 64'h3030303030303030);
        tick();
        no_pulse();
        tick();
        chk("rr2_ch0",  64'(ch), 64'd0);
        chk("rr2_col0", color,   64'h1010101010101010);
        tick();
        chk("rr2_ch1",  64'(ch), 64'd1);
        tick();
        chk("rr2_ch2",  64'(ch), 64'd2);
        chk("rr2_col2", color,   64'h3030303030303030);
        tick();

        // Backpressure: word must hold while ready is low
        ready = 1'b0;
        pulse(CH_G, 64'hA5A5A5A5A5A5A5A5);
        tick();
        no_pulse();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(valid), 64'd1);
            chk("bp_color", color,      64'hA5A5A5A5A5A5A5A5);
            chk("bp_ch",    64'(ch),    64'd1);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("bp_one_xfer", 64'(valid), 64'd0);

        // Overrun on ch2 while output is occupied by a ch0 word
        ready = 1'b0;
        pulse(CH_R, 64'hF0F0F0F0F0F0F0F0);
        tick();
        no_pulse();
        tick();
        pulse(CH_B, 64'h1111111111111111);
        tick();
        no_pulse();
        pulse(CH_B, 64'h2222222222222222);
        tick();
        no_pulse();
        chk("ovr_flags",  64'(overrun), 64'b100);
        chk("ovr_hold",   color,        64'hF0F0F0F0F0F0F0F0);
`ifdef BATCH_ARB_OVERRUN_CNT_EN
        chk("ovr_cnt1", 64'(ovr_cnt), 64'd1);
`endif
        ready = 1'b1;
        tick();
        chk("ovr_kept_old", color,   64'h1111111111111111);
        chk("ovr_kept_ch",  64'(ch), 64'd2);
        tick();
        chk("ovr_drain", 64'(valid), 64'd0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);
`ifdef BATCH_ARB_OVERRUN_CNT_EN
        chk("ovr_cnt_clr", 64'(ovr_cnt), 64'd0);
`endif

        // Same-edge grant and refill of ch0
        ready = 1'b0;
        pulse(CH_R, 64'hC0C0C0C0C0C0C0C0);
        tick();
        pulse(CH_R, 64'hC1C1C1C1C1C1C1C1);
        tick();
        no_pulse();
        chk("refill_no_ovr", 64'(overrun), 64'd0);
        chk("refill_first",  color,        64'hC0C0C0C0C0C0C0C0);
        ready = 1'b1;
        tick();
        chk("refill_second", color,   64'hC1C1C1C1C1C1C1C1);
        chk("refill_ch",     64'(ch), 64'd0);
        tick();
        chk("refill_drain", 64'(valid), 64'd0);

        // Asynchronous reset mid-stream
        ready = 1'b0;
        pulse(CH_G, 64'h5A5A5A5A5A5A5A5A);
        tick();
        no_pulse();
        pulse(CH_B, 64'h7777777777777777);
        tick();
        no_pulse();
        chk("ar_pre_valid", 64'(valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_async", 64'(valid), 64'd0);
        chk("ar_color_async", color,      64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        chk("ar_no_residue", 64'(valid), 64'd0);
        chk("ar_rr_last",    64'(dut.rr_last), 64'd2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
